// File: rtl/wb_xbar_rr_if.sv
// Wishbone bus bundle shared by masters, slaves and the round-robin crossbar.
// The slave modport faces a master; the master modport faces a slave.
interface wb_bus_t #(
  parameter int TAGSIZE = 2
);
  logic [31:0]        adr;
  logic [31:0]        dat_ms;
  logic [31:0]        dat_sm;
  logic [3:0]         sel;
  logic               we;
  logic               cyc;
  logic               stb;
  logic               lock;
  logic [TAGSIZE-1:0] tga;
  logic [TAGSIZE-1:0] tgc;
  logic [TAGSIZE-1:0] tgd_ms;
  logic [TAGSIZE-1:0] tgd_sm;
  logic               ack;
  logic               err;
  logic               rty;
  logic               gnt;

  modport slave (
    input  adr, dat_ms, sel, we, cyc, stb, lock, tga, tgc, tgd_ms,
    output dat_sm, tgd_sm, ack, err, rty, gnt
  );

  modport master (
    output adr, dat_ms, sel, we, cyc, stb, lock, tga, tgc, tgd_ms, gnt,
    input  dat_sm, tgd_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_xbar_rr.sv
// Shared-bus Wishbone interconnect: round-robin arbitration with bus locking,
// address-window decode, decode-miss errors and a no-response watchdog.
module wb_xbar_rr #(
  parameter int N_MASTER = 2,
  parameter int N_SLAVE  = 2,
  parameter int TAGSIZE  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] SSTART_ADDR [N_SLAVE],
  input  logic [31:0] SEND_ADDR   [N_SLAVE],
  wb_bus_t.slave      wb_slave_port  [N_MASTER],
  wb_bus_t.master     wb_master_port [N_SLAVE]
);

  localparam int MW  = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int SW  = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t              r_state;
  logic [N_MASTER-1:0] r_gnt;
  logic [MW-1:0]       r_ptr;
  logic [WDW-1:0]      r_wd;
  logic                r_decErr;

  logic [N_MASTER-1:0] w_mCyc;
  logic [N_MASTER-1:0] w_mStb;
  logic [N_MASTER-1:0] w_mWe;
  logic [N_MASTER-1:0] w_mLock;
  logic [31:0]         w_mAdr   [N_MASTER];
  logic [31:0]         w_mDat   [N_MASTER];
  logic [3:0]          w_mSel   [N_MASTER];
  logic [TAGSIZE-1:0]  w_mTga   [N_MASTER];
  logic [TAGSIZE-1:0]  w_mTgc   [N_MASTER];
  logic [TAGSIZE-1:0]  w_mTgd   [N_MASTER];

  logic [N_SLAVE-1:0]  w_sAck;
  logic [N_SLAVE-1:0]  w_sErr;
  logic [N_SLAVE-1:0]  w_sRty;
  logic [31:0]         w_sDat   [N_SLAVE];
  logic [TAGSIZE-1:0]  w_sTgd   [N_SLAVE];

  logic                w_own;
  logic                w_gCyc;
  logic                w_gStb;
  logic                w_gLock;
  logic [31:0]         w_gAdr;
  logic                w_req;
  logic                w_hit;
  logic [SW-1:0]       w_slv;
  logic                w_slvAck;
  logic                w_slvErr;
  logic                w_slvRty;
  logic                w_slvResp;
  logic                w_wdHit;
  logic                w_wdErr;
  logic [MW-1:0]       w_winner;

  for (genvar m = 0; m < N_MASTER; m++) begin : g_mst
    logic w_isG;
    assign w_isG      = w_own && (r_ptr == MW'(m));
    assign w_mCyc[m]  = wb_slave_port[m].cyc;
    assign w_mStb[m]  = wb_slave_port[m].stb;
    assign w_mWe[m]   = wb_slave_port[m].we;
    assign w_mLock[m] = wb_slave_port[m].lock;
    assign w_mAdr[m]  = wb_slave_port[m].adr;
    assign w_mDat[m]  = wb_slave_port[m].dat_ms;
    assign w_mSel[m]  = wb_slave_port[m].sel;
    assign w_mTga[m]  = wb_slave_port[m].tga;
    assign w_mTgc[m]  = wb_slave_port[m].tgc;
    assign w_mTgd[m]  = wb_slave_port[m].tgd_ms;

    assign wb_slave_port[m].ack    = w_isG && w_slvAck;
    assign wb_slave_port[m].rty    = w_isG && w_slvRty;
    assign wb_slave_port[m].err    = w_isG && (w_slvErr || w_wdErr || r_decErr);
    assign wb_slave_port[m].dat_sm = (w_isG && w_hit) ? w_sDat[w_slv] : '0;
    assign wb_slave_port[m].tgd_sm = (w_isG && w_hit) ? w_sTgd[w_slv] : '0;
    assign wb_slave_port[m].gnt    = r_gnt[m];
  end

  assign w_own   = !rst_i && (r_state != IDLE);
  assign w_gCyc  = w_mCyc[r_ptr];
  assign w_gStb  = w_mStb[r_ptr];
  assign w_gLock = w_mLock[r_ptr];
  assign w_gAdr  = w_mAdr[r_ptr];
  assign w_req   = w_own && w_gCyc && w_gStb;

  // Descending scan so that the lowest-index matching window wins on overlap.
  always_comb begin
    w_hit = 1'b0;
    w_slv = '0;
    for (int s = N_SLAVE - 1; s >= 0; s--) begin
      if ((w_gAdr >= SSTART_ADDR[s]) && (w_gAdr < SEND_ADDR[s])) begin
        w_hit = 1'b1;
        w_slv = SW'(s);
      end
    end
  end

  for (genvar s = 0; s < N_SLAVE; s++) begin : g_slv
    logic w_selS;
    assign w_selS    = w_own && w_hit && (w_slv == SW'(s));
    assign w_sAck[s] = wb_master_port[s].ack;
    assign w_sErr[s] = wb_master_port[s].err;
    assign w_sRty[s] = wb_master_port[s].rty;
    assign w_sDat[s] = wb_master_port[s].dat_sm;
    assign w_sTgd[s] = wb_master_port[s].tgd_sm;

    assign wb_master_port[s].cyc    = w_selS && w_gCyc;
    assign wb_master_port[s].stb    = w_selS && w_gCyc && w_gStb && !w_wdHit;
    assign wb_master_port[s].gnt    = w_selS;
    assign wb_master_port[s].adr    = w_gAdr - SSTART_ADDR[s];
    assign wb_master_port[s].dat_ms = w_mDat[r_ptr];
    assign wb_master_port[s].sel    = w_mSel[r_ptr];
    assign wb_master_port[s].we     = w_mWe[r_ptr];
    assign wb_master_port[s].lock   = w_mLock[r_ptr];
    assign wb_master_port[s].tga    = w_mTga[r_ptr];
    assign wb_master_port[s].tgc    = w_mTgc[r_ptr];
    assign wb_master_port[s].tgd_ms = w_mTgd[r_ptr];
  end

  assign w_slvAck  = w_hit && w_sAck[w_slv];
  assign w_slvErr  = w_hit && w_sErr[w_slv];
  assign w_slvRty  = w_hit && w_sRty[w_slv];
  assign w_slvResp = w_slvAck || w_slvErr || w_slvRty;
  assign w_wdHit   = (TIMEOUT != 0) && (r_wd == WDW'(TIMEOUT));
  // A real slave response in the expiry cycle suppresses the watchdog error.
  assign w_wdErr   = w_req && w_hit && w_wdHit && !w_slvResp;

  always_comb begin
    w_winner = r_ptr;
    for (int k = N_MASTER; k >= 1; k--) begin
      if (w_mCyc[(int'(r_ptr) + k) % N_MASTER]) begin
        w_winner = MW'((int'(r_ptr) + k) % N_MASTER);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= MW'(N_MASTER - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_mCyc) begin
            r_state         <= GRANT;
            r_ptr           <= w_winner;
            r_gnt           <= '0;
            r_gnt[w_winner] <= 1'b1;
          end
        end
        GRANT: begin
          if (!w_gCyc) begin
            if (w_gLock) begin
              r_state <= LOCKED;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
          end
        end
        LOCKED: begin
          if (w_gCyc) begin
            r_state <= GRANT;
          end else if (!w_gLock) begin
            r_state <= IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Decode-miss error pulses once per strobe; watchdog counts unanswered strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_decErr <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_decErr <= w_req && !w_hit && !r_decErr;
      if ((TIMEOUT == 0) || !w_req || !w_hit || w_slvResp || w_wdHit) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed bench for wb_xbar_rr: a scoreboard queue holds expected master
// responses, popped by a negedge monitor; bus-state checks are done inline.
module tb_wb_xbar_rr;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int TG = 2;
  localparam int TO = 4;

  typedef struct {
    int          m;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sStart [NS];
  logic [31:0] sEnd   [NS];

  logic        mCyc  [NM];
  logic        mStb  [NM];
  logic        mLock [NM];
  logic        mWe   [NM];
  logic [31:0] mAdr  [NM];
  logic [31:0] mDat  [NM];
  logic        mAck  [NM];
  logic        mErr  [NM];
  logic        mRty  [NM];
  logic        mGnt  [NM];
  logic [31:0] mDatSm [NM];

  logic        sAckEn [NS];
  logic        sCyc   [NS];
  logic        sStb   [NS];
  logic        sWe    [NS];
  logic [31:0] sAdr   [NS];
  logic [31:0] sDatMs [NS];
  logic [31:0] sLastWr [NS];

  logic [1:0]  gntV;
  logic [3:0]  sCS;

  exp_t        sbQ [$];
  exp_t        monExp;
  int          nTests = 0;
  int          nFail  = 0;

  int          lastWaited;
  logic        lastStbAtResp;
  logic [3:0]  lastCS;
  logic [31:0] lastAdr0;
  logic [31:0] lastAdr1;

  always #5 clk = ~clk;

  wb_bus_t #(.TAGSIZE(TG)) mIf [NM] ();
  wb_bus_t #(.TAGSIZE(TG)) sIf [NS] ();

  wb_xbar_rr #(
    .N_MASTER (NM),
    .N_SLAVE  (NS),
    .TAGSIZE  (TG),
    .TIMEOUT  (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .SSTART_ADDR    (sStart),
    .SEND_ADDR      (sEnd),
    .wb_slave_port  (mIf),
    .wb_master_port (sIf)
  );

  for (genvar m = 0; m < NM; m++) begin : g_m
    assign mIf[m].cyc    = mCyc[m];
    assign mIf[m].stb    = mStb[m];
    assign mIf[m].lock   = mLock[m];
    assign mIf[m].we     = mWe[m];
    assign mIf[m].adr    = mAdr[m];
    assign mIf[m].dat_ms = mDat[m];
    assign mIf[m].sel    = 4'hF;
    assign mIf[m].tga    = TG'(m);
    assign mIf[m].tgc    = '0;
    assign mIf[m].tgd_ms = '0;
    assign mAck[m]   = mIf[m].ack;
    assign mErr[m]   = mIf[m].err;
    assign mRty[m]   = mIf[m].rty;
    assign mGnt[m]   = mIf[m].gnt;
    assign mDatSm[m] = mIf[m].dat_sm;
  end

  // Slave model: registered single-cycle ack, read data tagged with slave index.
  for (genvar s = 0; s < NS; s++) begin : g_s
    logic        ackR;
    logic [31:0] datR;
    logic [31:0] wrR;
    assign sCyc[s]       = sIf[s].cyc;
    assign sStb[s]       = sIf[s].stb;
    assign sWe[s]        = sIf[s].we;
    assign sAdr[s]       = sIf[s].adr;
    assign sDatMs[s]     = sIf[s].dat_ms;
    assign sLastWr[s]    = wrR;
    assign sIf[s].ack    = ackR;
    assign sIf[s].err    = 1'b0;
    assign sIf[s].rty    = 1'b0;
    assign sIf[s].dat_sm = datR;
    assign sIf[s].tgd_sm = '0;
    always @(posedge clk) begin
      if (rst) begin
        ackR <= 1'b0;
        datR <= '0;
        wrR  <= '0;
      end else begin
        ackR <= sAckEn[s] && sCyc[s] && sStb[s] && !ackR;
        if (sCyc[s] && sStb[s] && !ackR) begin
          datR <= 32'hA000_0000 | (32'(s) << 24) | sAdr[s];
          if (sWe[s]) wrR <= sDatMs[s];
        end
      end
    end
  end

  assign gntV = {mGnt[1], mGnt[0]};
  assign sCS  = {sCyc[1], sStb[1], sCyc[0], sStb[0]};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (mAck[m] || mErr[m] || mRty[m]) begin
        nTests++;
        if (sbQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpected response: master %0d ack=%b err=%b rty=%b, expected none",
                   m, mAck[m], mErr[m], mRty[m]);
        end else begin
          monExp = sbQ.pop_front();
          if (monExp.m != m || monExp.ack !== mAck[m] || monExp.err !== mErr[m] ||
              monExp.rty !== mRty[m] || (monExp.ack && mDatSm[m] !== monExp.dat)) begin
            nFail++;
            $display("[TB] FAIL response: got m%0d ack=%b err=%b rty=%b dat=0x%08h, expected m%0d ack=%b err=%b rty=%b dat=0x%08h",
                     m, mAck[m], mErr[m], mRty[m], mDatSm[m],
                     monExp.m, monExp.ack, monExp.err, monExp.rty, monExp.dat);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One strobe from master m; assumes m already owns the bus.
  task automatic applyStimulus(input int m, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic expAck,
                               input logic expErr, input logic [31:0] expDat);
    exp_t e;
    e.m = m; e.ack = expAck; e.err = expErr; e.rty = 1'b0; e.dat = expDat;
    sbQ.push_back(e);
    step();
    mStb[m] = 1'b1; mWe[m] = we; mAdr[m] = adr; mDat[m] = dat;
    lastWaited = -1;
    lastStbAtResp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        lastCS = sCS; lastAdr0 = sAdr[0]; lastAdr1 = sAdr[1];
      end
      if (mAck[m] || mErr[m] || mRty[m]) begin
        lastWaited = i;
        lastStbAtResp = sStb[0] || sStb[1];
        break;
      end
    end
    if (lastWaited < 0) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL response wait: master %0d got no response within 20 cycles", m);
    end
    step();
    mStb[m] = 1'b0; mWe[m] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NM; i++) begin
      mCyc[i] = 1'b0; mStb[i] = 1'b0; mLock[i] = 1'b0; mWe[i] = 1'b0;
      mAdr[i] = '0; mDat[i] = '0;
    end
    for (int i = 0; i < NS; i++) sAckEn[i] = 1'b1;
    sStart[0] = 32'h0000_0100; sEnd[0] = 32'h0000_1000;
    sStart[1] = 32'h0000_1000; sEnd[1] = 32'h0000_2000;
    mCyc[0] = 1'b1; mStb[0] = 1'b1; mAdr[0] = 32'h0000_1004;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset gnt", 32'(gntV), 32'h0);
    checkOutput("reset slave cyc/stb", 32'(sCS), 32'h0);
    checkOutput("reset master ack/err", 32'({mAck[0], mErr[0], mAck[1], mErr[1]}), 32'h0);

    step();
    rst = 1'b0; mStb[0] = 1'b0; mCyc[1] = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", 32'(gntV), 32'h0);
    @(negedge clk);
    checkOutput("first grant m0", 32'(gntV), 32'h1);

    applyStimulus(0, 1'b0, 32'h0000_1004, 32'h0, 1'b1, 1'b0, 32'hA100_0004);
    checkOutput("read latency", 32'(lastWaited), 32'd1);
    checkOutput("read slave1 strobed only", 32'(lastCS), 32'hC);
    checkOutput("read slave1 local adr", lastAdr1, 32'h0000_0004);

    step();
    mCyc[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle gap after release", 32'(gntV), 32'h0);
    @(negedge clk);
    checkOutput("grant rotates to m1", 32'(gntV), 32'h2);

    applyStimulus(1, 1'b1, 32'h0000_0110, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hA000_0010);
    checkOutput("write slave0 strobed only", 32'(lastCS), 32'h3);
    checkOutput("write slave0 local adr", lastAdr0, 32'h0000_0010);
    checkOutput("write data reached slave0", sLastWr[0], 32'hDEAD_BEEF);

    step();
    mLock[1] = 1'b1; mCyc[1] = 1'b0; mCyc[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("lock hold 1", 32'(gntV), 32'h2);
    @(negedge clk);
    checkOutput("lock hold 2", 32'(gntV), 32'h2);
    step();
    mLock[1] = 1'b0;
    @(negedge clk);
    checkOutput("lock hold 3", 32'(gntV), 32'h2);
    @(negedge clk);
    checkOutput("idle after unlock", 32'(gntV), 32'h0);
    @(negedge clk);
    checkOutput("m0 granted after unlock", 32'(gntV), 32'h1);

    applyStimulus(0, 1'b0, 32'h9000_0000, 32'h0, 1'b0, 1'b1, 32'h0);
    checkOutput("decode miss err latency", 32'(lastWaited), 32'd1);
    checkOutput("decode miss no slave", 32'(lastCS), 32'h0);

    sEnd[0] = 32'h0000_1800;
    applyStimulus(0, 1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0, 32'hA000_0F10);
    checkOutput("overlap lowest wins", 32'(lastCS), 32'h3);
    checkOutput("overlap local adr", lastAdr0, 32'h0000_0F10);
    sEnd[0] = 32'h0000_1000;

    sAckEn[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("watchdog latency %0d", r), 32'(lastWaited), 32'd4);
      checkOutput($sformatf("watchdog stb forced low %0d", r), 32'(lastStbAtResp), 32'h0);
    end
    sAckEn[1] = 1'b1;

    step();
    mCyc[1] = 1'b1; mStb[0] = 1'b1; mWe[0] = 1'b1;
    mAdr[0] = 32'h0000_1000; mDat[0] = 32'h1234_5678;
    @(negedge clk);
    checkOutput("write strobe before reset", 32'(sCS), 32'hC);
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("strobe gated in reset", 32'(sCS), 32'h0);
    step();
    mStb[0] = 1'b0; mWe[0] = 1'b0;
    @(negedge clk);
    checkOutput("gnt cleared by reset", 32'(gntV), 32'h0);
    checkOutput("no strobe after reset", 32'(sCS), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("m0 first after reset", 32'(gntV), 32'h1);

    step();
    mCyc[0] = 1'b0; mCyc[1] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global timeout: bench did not complete, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
